gray_to_rgb_expander: RTL and testbench
=======================================

Name: gray_to_rgb_expander

Overview:
- Consumer end of the grayscale pixel stream: takes 8-bit gray plus its valid strobe and X/Y counters.
- Re-expands each pixel to 12-bit R/G/B for the display/RGB path.
- Checks raster order against the configured frame geometry and resynchronises on the next frame origin.
- Sits between the gray conversion stage and the LCD/frame-buffer write path.

Parameters:
H_ACTIVE, 800, pixels per line; valid X range 0..H_ACTIVE-1
V_ACTIVE, 480, lines per frame; valid Y range 0..V_ACTIVE-1
THRESH, 8'd128, binary-mode threshold; gray >= THRESH gives white

Ports:
iCLK  input  1  clock
iReset_n  input  1  synchronous active-low reset
iGray  input  8  gray pixel
iDval  input  1  pixel valid
iX_Cont  input  16  pixel column
iY_Cont  input  16  pixel row
iMode  input  1  0 = replicate, 1 = binary threshold
oRed  output  12  red channel
oGreen  output  12  green channel
oBlue  output  12  blue channel
oDval  output  1  output pixel valid
oX_Cont  output  16  column of output pixel
oY_Cont  output  16  row of output pixel
oFrameDone  output  1  one-cycle pulse with the last pixel of a frame
oSyncErr  output  1  one-cycle pulse on an out-of-order pixel
oFrameCount  output  16  completed frames

Behaviour:
- One clock (iCLK); reset is synchronous and active-low (iReset_n), sampled on posedge iCLK.
- Reset: all outputs 0, state SYNC, expected (eX,eY)=(0,0), latched mode 0. Reset mid-frame discards all in-flight pixels.
- Pipeline: 2-cycle fixed latency from input sample to outputs; all outputs registered.
- Stage 1 registers the inputs and makes the accept/drop decision; stage 2 expands the pixel and drives outputs.
- oX_Cont/oY_Cont/oDval/pulses travel aligned with their pixel.
- Cycles with iDval=0: no state change; oDval=0 two cycles later.
- FSM states: SYNC, ACTIVE.
- SYNC:
  - Valid pixel at (0,0): accept, latch iMode, set expected (1,0), go to ACTIVE.
  - Any other valid pixel: drop silently, no error.
- ACTIVE, valid pixel matching (eX,eY): accept and advance expected.
  - If eX=H_ACTIVE-1: eX=0, eY=eY+1.
  - If also eY=V_ACTIVE-1: pulse oFrameDone with this pixel, oFrameCount+1, go to SYNC.
- ACTIVE, valid pixel not matching:
  - Pulse oSyncErr in this pixel's output slot with oDval=0; drop the pixel; go to SYNC.
  - Exception: if the mismatched pixel is (0,0), still pulse oSyncErr, but accept it as a new frame start (latch mode, expected (1,0), stay ACTIVE) with oDval=1.
- Frame of one pixel (H_ACTIVE=V_ACTIVE=1): the (0,0) pixel is accepted and also raises oFrameDone.
- Expansion, replicate mode: each channel = {g, g[7:4]}. 0x00 -> 0x000, 0x80 -> 0x808, 0xFF -> 0xFFF.
- Expansion, binary mode: all channels 0xFFF if g >= THRESH, else 0x000.
- Mode is latched only at frame start; iMode changes mid-frame have no effect until the next (0,0).
- oFrameCount wraps 0xFFFF -> 0x0000 with no flag.
- Outputs for dropped pixels: oDval=0; colour/coordinates hold their previous values.

Decomposition:
- Shared package: state encoding (SYNC, ACTIVE), the expansion function, and the default geometry constants (800/480), reused by the other display-path blocks.
- One natural sub-module, gray_raster_tracker: FSM, expected counters, frame counter, accept/err/done decision.
- Top level holds the 2-stage data pipeline and the expansion.

Test Plan:
- Bench uses H_ACTIVE=4, V_ACTIVE=2.
- Clean frame, mode 0, gray 0x00,0x80,0xFF,0x10,...: 8 outputs, each 2 cycles after input; colours 0x000,0x808,0xFFF,0x101; oFrameDone with pixel (3,1); oFrameCount=1.
- Stream starting at (2,0) then a full frame: first 2 pixels dropped with oSyncErr=0; the following frame is fully output.
- In ACTIVE, (1,0) followed by (3,0): oSyncErr pulse, (3,0) dropped; remaining pixels dropped until the next (0,0), which is accepted.
- Mismatch where the pixel is (0,0) mid-frame: oSyncErr=1 and oDval=1 in the same cycle; the new frame completes normally.
- iMode=1 at frame start, toggled to 0 mid-frame, gray 0x7F/0x80: outputs 0x000/0xFFF for the whole frame; replicate mode applies from the next frame.
- iReset_n low for 1 cycle mid-frame: next cycle all outputs 0, oFrameCount=0, state SYNC; pixels in flight are not output; 65536 frames after reset wrap oFrameCount to 0.

Source files
------------

// File: rtl/gray_to_rgb_expander_pkg.sv
// Shared display-path definitions: raster tracker state encoding, default
// panel geometry and the gray-to-12-bit colour expansion.
package gray_to_rgb_expander_pkg;

   // Default active geometry of the 800x480 LCD panel.
   localparam int         DEF_H_ACTIVE = 800;
   localparam int         DEF_V_ACTIVE = 480;

   // Default binary-mode threshold: gray at or above this value becomes white.
   localparam logic [7:0] DEF_THRESH   = 8'd128;

   // Raster tracker states.
   //   SYNC   : hunting for the next frame origin (0,0); anything else is dropped.
   //   ACTIVE : inside a frame, each pixel must match the expected position.
   typedef enum logic {
      SYNC   = 1'b0,
      ACTIVE = 1'b1
   } raster_state_t;

   // Expand one 8-bit gray sample to a 12-bit channel value.
   //   binMode = 0 : replicate the top nibble into the low bits so that
   //                 0x00 -> 0x000 and 0xFF -> 0xFFF (full-scale preserved).
   //   binMode = 1 : hard threshold, result is either black or full white.
   function automatic logic [11:0] expand_gray(
      input logic [7:0] gray,
      input logic       binMode,
      input logic [7:0] thresh
   );
      logic [11:0] chan;
      if (binMode) begin
         chan = (gray >= thresh) ? 12'hFFF : 12'h000;
      end else begin
         chan = {gray, gray[7:4]};
      end
      return chan;
   endfunction

endpackage

// File: rtl/gray_to_rgb_expander_if.sv
// Pixel stream bundle between the gray conversion stage, this expander and
// the LCD / frame-buffer write path.
//
// Transfer rule: the stream has no backpressure. A pixel is transferred on
// every rising iCLK edge where iDval=1; iGray/iX_Cont/iY_Cont/iMode are only
// meaningful in that cycle. On the output side a pixel is presented in every
// cycle with oDval=1; the consumer must take it in that cycle. oFrameDone and
// oSyncErr are single-cycle pulses aligned with the pixel slot they describe.
interface gray_to_rgb_expander_if;
   import gray_to_rgb_expander_pkg::*;

   // Upstream (gray) side.
   logic [7:0]    iGray;
   logic          iDval;
   logic [15:0]   iX_Cont;
   logic [15:0]   iY_Cont;
   logic          iMode;

   // Downstream (RGB) side.
   logic [11:0]   oRed;
   logic [11:0]   oGreen;
   logic [11:0]   oBlue;
   logic          oDval;
   logic [15:0]   oX_Cont;
   logic [15:0]   oY_Cont;
   logic          oFrameDone;
   logic          oSyncErr;
   logic [15:0]   oFrameCount;

   // Raster tracker state, exposed for observation.
   raster_state_t dbgState;

   // Source of gray pixels and sink of RGB pixels.
   modport master (
      output iGray, iDval, iX_Cont, iY_Cont, iMode,
      input  oRed, oGreen, oBlue, oDval, oX_Cont, oY_Cont,
      input  oFrameDone, oSyncErr, oFrameCount, dbgState
   );

   // The expander itself.
   modport slave (
      input  iGray, iDval, iX_Cont, iY_Cont, iMode,
      output oRed, oGreen, oBlue, oDval, oX_Cont, oY_Cont,
      output oFrameDone, oSyncErr, oFrameCount, dbgState
   );

endinterface

// File: rtl/gray_to_rgb_expander_raster_tracker.sv
// Raster order tracker: decides, for each incoming valid pixel, whether it is
// accepted, dropped, or flags a sync error, and counts completed frames.
// The accept/error/done decision is combinational on the current pixel so the
// caller can register it together with the pixel data.
module gray_raster_tracker
   import gray_to_rgb_expander_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE
) (
   input  logic          iCLK,
   input  logic          iReset_n,
   input  logic          iDval,
   input  logic [15:0]   iX_Cont,
   input  logic [15:0]   iY_Cont,
   input  logic          iMode,
   output logic          oAccept,
   output logic          oSyncErr,
   output logic          oFrameDone,
   output logic          oPixMode,
   output logic [15:0]   oFrameCount,
   output raster_state_t oState
);

   localparam logic [15:0] LAST_X = 16'(H_ACTIVE - 1);
   localparam logic [15:0] LAST_Y = 16'(V_ACTIVE - 1);

   raster_state_t state;
   raster_state_t nextState;
   logic [15:0]   eX;
   logic [15:0]   eY;
   logic [15:0]   nextEx;
   logic [15:0]   nextEy;
   logic [15:0]   frameCount;
   logic [15:0]   nextFrameCount;
   logic          modeLatched;
   logic          nextMode;
   logic          isOrigin;
   logic          isExpected;
   logic          takePixel;
   logic          syncErr;
   logic          frameDone;

   // State register: FSM state, expected position, latched mode, frame count.
   always_ff @(posedge iCLK) begin
      if (!iReset_n) begin
         state       <= SYNC;
         eX          <= 16'd0;
         eY          <= 16'd0;
         modeLatched <= 1'b0;
         frameCount  <= 16'd0;
      end else begin
         state       <= nextState;
         eX          <= nextEx;
         eY          <= nextEy;
         modeLatched <= nextMode;
         frameCount  <= nextFrameCount;
      end
   end

   // Next-state logic and per-pixel accept / error / frame-done decision.
   always_comb begin
      nextState      = state;
      nextEx         = eX;
      nextEy         = eY;
      nextMode       = modeLatched;
      nextFrameCount = frameCount;
      takePixel      = 1'b0;
      syncErr        = 1'b0;
      frameDone      = 1'b0;
      isOrigin       = (iX_Cont == 16'd0) && (iY_Cont == 16'd0);
      isExpected     = (iX_Cont == eX) && (iY_Cont == eY);

      if (iDval) begin
         case (state)
            SYNC: begin
               // Only a frame origin ends the hunt; other pixels vanish quietly.
               takePixel = isOrigin;
            end
            ACTIVE: begin
               if (isExpected) begin
                  takePixel = 1'b1;
               end else begin
                  // Out of order. An origin is still usable as a fresh start,
                  // anything else forces a resync.
                  syncErr   = 1'b1;
                  takePixel = isOrigin;
                  if (!isOrigin) begin
                     nextState = SYNC;
                     nextEx    = 16'd0;
                     nextEy    = 16'd0;
                  end
               end
            end
            default: begin
               nextState = SYNC;
            end
         endcase
      end

      if (takePixel) begin
         // Mode only changes at a frame origin and applies to that pixel.
         if (isOrigin) begin
            nextMode = iMode;
         end
         nextState = ACTIVE;
         if (iX_Cont == LAST_X) begin
            nextEx = 16'd0;
            if (iY_Cont == LAST_Y) begin
               // Last pixel of the frame: close it and hunt for the next origin.
               nextEy         = 16'd0;
               frameDone      = 1'b1;
               nextFrameCount = frameCount + 16'd1;
               nextState      = SYNC;
            end else begin
               nextEy = iY_Cont + 16'd1;
            end
         end else begin
            nextEx = iX_Cont + 16'd1;
            nextEy = iY_Cont;
         end
      end
   end

   assign oAccept     = takePixel;
   assign oSyncErr    = syncErr;
   assign oFrameDone  = frameDone;
   assign oPixMode    = nextMode;
   assign oFrameCount = frameCount;
   assign oState      = state;

endmodule

// File: rtl/gray_to_rgb_expander.sv
// Gray-to-RGB expander: two-stage pipeline between the gray conversion stage
// and the LCD / frame-buffer write path.
//   stage 1 : register the pixel and the tracker's accept/drop decision
//   stage 2 : expand the accepted pixel to 12-bit R/G/B and drive outputs
// Fixed latency of two clocks from input sample to registered outputs.
module gray_to_rgb_expander
   import gray_to_rgb_expander_pkg::*;
#(
   parameter int         H_ACTIVE = DEF_H_ACTIVE,
   parameter int         V_ACTIVE = DEF_V_ACTIVE,
   parameter logic [7:0] THRESH   = DEF_THRESH
) (
   input  logic                    iCLK,
   input  logic                    iReset_n,
   gray_to_rgb_expander_if.slave   pix
);

   // Tracker decision for the pixel currently on the inputs.
   logic          trkAccept;
   logic          trkSyncErr;
   logic          trkFrameDone;
   logic          trkPixMode;
   logic [15:0]   trkFrameCount;
   raster_state_t trkState;

   // Stage 1 registers.
   logic [7:0]    s1Gray;
   logic [15:0]   s1X;
   logic [15:0]   s1Y;
   logic          s1Accept;
   logic          s1SyncErr;
   logic          s1FrameDone;
   logic          s1Mode;

   // Stage 2 expansion result.
   logic [11:0]   chan;

   gray_raster_tracker #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE)
   ) u_tracker (
      .iCLK        (iCLK),
      .iReset_n    (iReset_n),
      .iDval       (pix.iDval),
      .iX_Cont     (pix.iX_Cont),
      .iY_Cont     (pix.iY_Cont),
      .iMode       (pix.iMode),
      .oAccept     (trkAccept),
      .oSyncErr    (trkSyncErr),
      .oFrameDone  (trkFrameDone),
      .oPixMode    (trkPixMode),
      .oFrameCount (trkFrameCount),
      .oState      (trkState)
   );

   // Stage 1: capture the pixel together with its accept/err/done verdict.
   always_ff @(posedge iCLK) begin
      if (!iReset_n) begin
         s1Gray      <= 8'd0;
         s1X         <= 16'd0;
         s1Y         <= 16'd0;
         s1Accept    <= 1'b0;
         s1SyncErr   <= 1'b0;
         s1FrameDone <= 1'b0;
         s1Mode      <= 1'b0;
      end else begin
         s1Gray      <= pix.iGray;
         s1X         <= pix.iX_Cont;
         s1Y         <= pix.iY_Cont;
         s1Accept    <= trkAccept;
         s1SyncErr   <= trkSyncErr;
         s1FrameDone <= trkFrameDone;
         s1Mode      <= trkPixMode;
      end
   end

   // The three channels are identical for a gray source.
   assign chan = expand_gray(s1Gray, s1Mode, THRESH);

   // Stage 2: drive outputs; dropped pixels leave colour and position untouched.
   always_ff @(posedge iCLK) begin
      if (!iReset_n) begin
         pix.oRed        <= 12'd0;
         pix.oGreen      <= 12'd0;
         pix.oBlue       <= 12'd0;
         pix.oX_Cont     <= 16'd0;
         pix.oY_Cont     <= 16'd0;
         pix.oDval       <= 1'b0;
         pix.oFrameDone  <= 1'b0;
         pix.oSyncErr    <= 1'b0;
         pix.oFrameCount <= 16'd0;
      end else begin
         pix.oDval       <= s1Accept;
         pix.oFrameDone  <= s1FrameDone;
         pix.oSyncErr    <= s1SyncErr;
         // The tracker count already includes this slot's frame-done, so the
         // new count appears together with the oFrameDone pulse.
         pix.oFrameCount <= trkFrameCount;
         if (s1Accept) begin
            pix.oRed    <= chan;
            pix.oGreen  <= chan;
            pix.oBlue   <= chan;
            pix.oX_Cont <= s1X;
            pix.oY_Cont <= s1Y;
         end
      end
   end

   assign pix.dbgState = trkState;

endmodule

// File: tb/tb_gray_to_rgb_expander.sv
// Bench for gray_to_rgb_expander: a 4x2 instance checked every cycle against a
// frame-index model, plus a 1x1 instance used for the one-pixel frame and the
// frame counter wrap.
module tb_gray_to_rgb_expander;
   import gray_to_rgb_expander_pkg::*;

   localparam int H = 4;
   localparam int V = 2;

   // ---------------- clock / reset ----------------
   logic iCLK     = 1'b0;
   logic iReset_n = 1'b0;
   always #5 iCLK = ~iCLK;

   gray_to_rgb_expander_if busA ();
   gray_to_rgb_expander_if busB ();

   gray_to_rgb_expander #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .THRESH   (8'd128)
   ) dutA (
      .iCLK     (iCLK),
      .iReset_n (iReset_n),
      .pix      (busA)
   );

   gray_to_rgb_expander #(
      .H_ACTIVE (1),
      .V_ACTIVE (1),
      .THRESH   (8'd128)
   ) dutB (
      .iCLK     (iCLK),
      .iReset_n (iReset_n),
      .pix      (busB)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        dval;
      logic        done;
      logic        err;
      logic [11:0] r;
      logic [11:0] g;
      logic [11:0] b;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] cnt;
   } out_t;
   localparam int W = $bits(out_t);

   typedef struct packed {
      logic        dval;
      logic        done;
      logic        err;
      logic [15:0] cnt;
   } bout_t;
   localparam int WB = $bits(bout_t);

   logic [W-1:0]  exp_q[$];
   logic [WB-1:0] bexp_q[$];

   // Observations used by the directed literal checks.
   logic [11:0] capR[$];
   int errPulses  = 0;
   int errDval    = 0;
   int donePulses = 0;
   int bDone      = 0;

   logic [7:0] t1Gray [8];

   // ---------------- model ----------------
   // Frame position is tracked as a linear index y*H+x; -1 means hunting for
   // the origin.
   int          mdlNext  = -1;
   logic        mdlMode  = 1'b0;
   logic [15:0] mdlCount = 16'd0;
   out_t        mdlLast  = '0;
   out_t        mdlE;
   int          mdlIdx;
   logic        mdlTake;
   logic [15:0] bCount   = 16'd0;
   bout_t       bE;

   function automatic logic [11:0] model_colour(input logic [7:0] gv, input logic m);
      int v;
      if (m) v = (int'(gv) >= 128) ? 4095 : 0;
      else   v = int'(gv) * 16 + int'(gv) / 16;
      return 12'(v);
   endfunction

   // Model: one expected output slot per clock, queued two slots deep.
   always @(posedge iCLK) begin
      if (!iReset_n) begin
         mdlNext  = -1;
         mdlMode  = 1'b0;
         mdlCount = 16'd0;
         mdlLast  = '0;
         exp_q.delete();
         exp_q.push_back('0);
         exp_q.push_back('0);
         bCount = 16'd0;
         bexp_q.delete();
         bexp_q.push_back('0);
         bexp_q.push_back('0);
      end else begin
         mdlE      = mdlLast;
         mdlE.dval = 1'b0;
         mdlE.done = 1'b0;
         mdlE.err  = 1'b0;
         if (busA.iDval) begin
            if (busA.iX_Cont < 16'(H) && busA.iY_Cont < 16'(V))
               mdlIdx = int'(busA.iY_Cont) * H + int'(busA.iX_Cont);
            else
               mdlIdx = -2;
            mdlTake = 1'b0;
            if (mdlNext < 0) begin
               mdlTake = (mdlIdx == 0);
            end else if (mdlIdx == mdlNext) begin
               mdlTake = 1'b1;
            end else begin
               mdlE.err = 1'b1;
               mdlTake  = (mdlIdx == 0);
               if (!mdlTake) mdlNext = -1;
            end
            if (mdlTake) begin
               if (mdlIdx == 0) mdlMode = busA.iMode;
               mdlE.dval = 1'b1;
               mdlE.r    = model_colour(busA.iGray, mdlMode);
               mdlE.g    = mdlE.r;
               mdlE.b    = mdlE.r;
               mdlE.x    = busA.iX_Cont;
               mdlE.y    = busA.iY_Cont;
               mdlNext   = mdlIdx + 1;
               if (mdlNext == H * V) begin
                  mdlE.done = 1'b1;
                  mdlCount  = mdlCount + 16'd1;
                  mdlNext   = -1;
               end
            end
         end
         mdlE.cnt = mdlCount;
         exp_q.push_back(mdlE);
         mdlLast = mdlE;

         // 1x1 geometry: every valid origin pixel is a whole frame.
         bE = '0;
         if (busB.iDval && busB.iX_Cont == 16'd0 && busB.iY_Cont == 16'd0) begin
            bE.dval = 1'b1;
            bE.done = 1'b1;
            bCount  = bCount + 16'd1;
         end
         bE.cnt = bCount;
         bexp_q.push_back(bE);
      end
   end

   // ---------------- scoreboard / compare ----------------
   out_t  actA, expA;
   bout_t actB, expB;

   always @(negedge iCLK) begin
      if (exp_q.size() == 2) begin
         expA      = exp_q.pop_front();
         actA.dval = busA.oDval;
         actA.done = busA.oFrameDone;
         actA.err  = busA.oSyncErr;
         actA.r    = busA.oRed;
         actA.g    = busA.oGreen;
         actA.b    = busA.oBlue;
         actA.x    = busA.oX_Cont;
         actA.y    = busA.oY_Cont;
         actA.cnt  = busA.oFrameCount;
         checks++;
         if (actA !== expA) begin
            errors++;
            $display("FAIL pixel_out t=%0t got dval=%b done=%b err=%b rgb=%h/%h/%h xy=%0d,%0d cnt=%0d required dval=%b done=%b err=%b rgb=%h/%h/%h xy=%0d,%0d cnt=%0d",
                     $time, actA.dval, actA.done, actA.err, actA.r, actA.g, actA.b, actA.x, actA.y, actA.cnt,
                     expA.dval, expA.done, expA.err, expA.r, expA.g, expA.b, expA.x, expA.y, expA.cnt);
         end
      end
      if (bexp_q.size() == 2) begin
         expB      = bexp_q.pop_front();
         actB.dval = busB.oDval;
         actB.done = busB.oFrameDone;
         actB.err  = busB.oSyncErr;
         actB.cnt  = busB.oFrameCount;
         checks++;
         if (actB !== expB) begin
            errors++;
            $display("FAIL one_pixel_out t=%0t got dval=%b done=%b err=%b cnt=%0d required dval=%b done=%b err=%b cnt=%0d",
                     $time, actB.dval, actB.done, actB.err, actB.cnt, expB.dval, expB.done, expB.err, expB.cnt);
         end
      end
      if (busA.oDval === 1'b1) capR.push_back(busA.oRed);
      if (busA.oSyncErr === 1'b1) errPulses++;
      if (busA.oSyncErr === 1'b1 && busA.oDval === 1'b1) errDval++;
      if (busA.oFrameDone === 1'b1) donePulses++;
      if (busB.oFrameDone === 1'b1) bDone++;
   end

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h required %0h", name, act, req);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic px(input int x, input int y, input logic [7:0] gv, input logic m);
      @(negedge iCLK);
      busA.iDval   = 1'b1;
      busA.iX_Cont = 16'(x);
      busA.iY_Cont = 16'(y);
      busA.iGray   = gv;
      busA.iMode   = m;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge iCLK);
         busA.iDval = 1'b0;
         busB.iDval = 1'b0;
      end
   endtask

   task automatic frame_a(input logic [7:0] gv, input logic m);
      for (int i = 0; i < H * V; i++) px(i % H, i / H, gv, m);
   endtask

   // ---------------- stimulus ----------------
   int base;
   int e0;
   int d0;

   initial begin
      busA.iDval = 1'b0; busA.iGray = 8'd0; busA.iX_Cont = 16'd0; busA.iY_Cont = 16'd0; busA.iMode = 1'b0;
      busB.iDval = 1'b0; busB.iGray = 8'hFF; busB.iX_Cont = 16'd0; busB.iY_Cont = 16'd0; busB.iMode = 1'b0;
      t1Gray = '{8'h00, 8'h80, 8'hFF, 8'h10, 8'h20, 8'h40, 8'hC0, 8'h01};

      // Reset values.
      iReset_n = 1'b0;
      repeat (2) @(negedge iCLK);
      #1;
      check_eq("reset_dval",  32'(busA.oDval), 32'd0);
      check_eq("reset_count", 32'(busA.oFrameCount), 32'd0);
      check_eq("reset_red",   32'(busA.oRed), 32'd0);
      check_eq("reset_state", 32'(busA.dbgState), 32'(SYNC));
      @(negedge iCLK);
      iReset_n = 1'b1;

      // Clean frame, replicate mode.
      base = capR.size();
      for (int i = 0; i < 8; i++) px(i % H, i / H, t1Gray[i], 1'b0);
      idle(3);
      check_eq("t1_outputs", 32'(capR.size() - base), 32'd8);
      check_eq("t1_c0", 32'(capR[base]),     32'h000);
      check_eq("t1_c1", 32'(capR[base + 1]), 32'h808);
      check_eq("t1_c2", 32'(capR[base + 2]), 32'hFFF);
      check_eq("t1_c3", 32'(capR[base + 3]), 32'h101);
      check_eq("t1_c7", 32'(capR[base + 7]), 32'h010);
      check_eq("t1_done", 32'(donePulses), 32'd1);
      check_eq("t1_count", 32'(busA.oFrameCount), 32'd1);

      // Stream joined mid-frame: leading pixels dropped without error.
      base = capR.size(); e0 = errPulses;
      px(2, 0, 8'h33, 1'b0);
      px(3, 0, 8'h33, 1'b0);
      frame_a(8'h10, 1'b0);
      idle(3);
      check_eq("t2_outputs", 32'(capR.size() - base), 32'd8);
      check_eq("t2_no_err", 32'(errPulses - e0), 32'd0);
      check_eq("t2_count", 32'(busA.oFrameCount), 32'd2);

      // Skipped pixel: error, resync at the next origin.
      base = capR.size(); e0 = errPulses; d0 = errDval;
      px(0, 0, 8'h20, 1'b0);
      px(1, 0, 8'h20, 1'b0);
      px(3, 0, 8'h20, 1'b0);
      px(0, 1, 8'h20, 1'b0);
      px(1, 1, 8'h20, 1'b0);
      frame_a(8'h40, 1'b0);
      idle(3);
      check_eq("t3_outputs", 32'(capR.size() - base), 32'd10);
      check_eq("t3_err", 32'(errPulses - e0), 32'd1);
      check_eq("t3_err_nodval", 32'(errDval - d0), 32'd0);
      check_eq("t3_count", 32'(busA.oFrameCount), 32'd3);

      // Premature origin: error and restart in the same slot.
      base = capR.size(); e0 = errPulses; d0 = errDval;
      px(0, 0, 8'h50, 1'b0);
      px(1, 0, 8'h50, 1'b0);
      frame_a(8'h60, 1'b0);
      idle(3);
      check_eq("t4_outputs", 32'(capR.size() - base), 32'd10);
      check_eq("t4_err", 32'(errPulses - e0), 32'd1);
      check_eq("t4_err_dval", 32'(errDval - d0), 32'd1);
      check_eq("t4_count", 32'(busA.oFrameCount), 32'd4);

      // Binary mode latched at frame start; mid-frame mode change ignored.
      base = capR.size();
      for (int i = 0; i < 8; i++) px(i % H, i / H, (i % 2 == 1) ? 8'h80 : 8'h7F, (i < 3) ? 1'b1 : 1'b0);
      frame_a(8'h80, 1'b0);
      idle(3);
      check_eq("t5_outputs", 32'(capR.size() - base), 32'd16);
      check_eq("t5_c0", 32'(capR[base]),     32'h000);
      check_eq("t5_c1", 32'(capR[base + 1]), 32'hFFF);
      check_eq("t5_c6", 32'(capR[base + 6]), 32'h000);
      check_eq("t5_c7", 32'(capR[base + 7]), 32'hFFF);
      check_eq("t5_next", 32'(capR[base + 8]), 32'h808);
      check_eq("t5_count", 32'(busA.oFrameCount), 32'd6);

      // One-cycle reset mid-frame.
      px(0, 0, 8'h55, 1'b0);
      px(1, 0, 8'h66, 1'b0);
      @(negedge iCLK);
      iReset_n     = 1'b0;
      busA.iX_Cont = 16'd2;
      busA.iGray   = 8'h77;
      @(negedge iCLK);
      iReset_n   = 1'b1;
      busA.iDval = 1'b0;
      #1;
      check_eq("t6_dval",  32'(busA.oDval), 32'd0);
      check_eq("t6_count", 32'(busA.oFrameCount), 32'd0);
      check_eq("t6_red",   32'(busA.oRed), 32'd0);
      check_eq("t6_x",     32'(busA.oX_Cont), 32'd0);
      check_eq("t6_state", 32'(busA.dbgState), 32'(SYNC));
      base = capR.size(); e0 = errPulses;
      px(2, 0, 8'h77, 1'b0);
      px(3, 0, 8'h77, 1'b0);
      idle(3);
      check_eq("t6_inflight", 32'(capR.size() - base), 32'd0);
      check_eq("t6_no_err", 32'(errPulses - e0), 32'd0);
      frame_a(8'hA0, 1'b0);
      idle(3);
      check_eq("t6_count_after", 32'(busA.oFrameCount), 32'd1);

      // One-pixel frames and the frame counter wrap.
      @(negedge iCLK);
      busB.iDval = 1'b1;
      idle(3);
      check_eq("b_count1", 32'(busB.oFrameCount), 32'd1);
      check_eq("b_red", 32'(busB.oRed), 32'hFFF);
      check_eq("b_done1", 32'(bDone), 32'd1);
      repeat (65535) begin
         @(negedge iCLK);
         busB.iDval = 1'b1;
      end
      idle(3);
      check_eq("b_wrap", 32'(busB.oFrameCount), 32'd0);
      check_eq("b_done_all", 32'(bDone), 32'd65536);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
